// File: rtl/program_sequencer.sv
// Run-control FSM: launches a selected program on the core, watches pc for its done address
// and acknowledges on completion or cycle-budget timeout. Optional step mode: PROGRAM_SEQUENCER_STEP_EN.
module program_sequencer #(
  parameter int unsigned           PC_BITS     = 10,
  parameter int unsigned           NUM_PROGS   = 3,
  parameter logic [4*PC_BITS-1:0]  START_ADDRS = {10'd0, 10'd0, 10'd0, 10'd0},
  parameter logic [4*PC_BITS-1:0]  DONE_ADDRS  = {10'd0, 10'd0, 10'd0, 10'd23},
  parameter int unsigned           CNT_BITS    = 16,
  parameter logic [CNT_BITS-1:0]   MAX_CYCLES  = 16'd50000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req,
  input  logic [1:0]          prog_sel,
  input  logic [PC_BITS-1:0]  pc,
  output logic                start,
  output logic [PC_BITS-1:0]  start_addr,
  output logic                busy,
  output logic                ack,
  output logic                timeout,
  output logic [CNT_BITS-1:0] cycle_count,
  output logic                sel_err
`ifdef PROGRAM_SEQUENCER_STEP_EN
  ,
  input  logic                step,
  output logic                stall
`endif
);

  localparam logic [2:0]          NumProgs  = 3'(NUM_PROGS);
  localparam logic [CNT_BITS-1:0] LastCycle = MAX_CYCLES - 1'b1;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StTout} state_e;

  state_e             state_q;
  logic               req_q;
  logic               first_q;
  logic [PC_BITS-1:0] done_addr_q;

  logic                req_rise;
  logic                sel_ok;
  logic                advance;
  logic                match;
  logic                budget;
  logic                finish;
  logic [CNT_BITS-1:0] count_inc;

  assign req_rise  = req & ~req_q;
  assign sel_ok    = {1'b0, prog_sel} < NumProgs;
  // The core only executes on cycles where stall is low, so only those cycles are counted.
`ifdef PROGRAM_SEQUENCER_STEP_EN
  assign advance   = ~stall;
`else
  assign advance   = 1'b1;
`endif
  // First RUN cycle is excluded so a program whose start equals its done address still runs.
  assign match     = ~first_q & (pc == done_addr_q);
  assign budget    = (cycle_count == LastCycle);
  assign finish    = advance & (match | budget);
  assign count_inc = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      first_q     <= 1'b0;
      done_addr_q <= '0;
      start       <= 1'b0;
      start_addr  <= '0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      sel_err     <= 1'b0;
`ifdef PROGRAM_SEQUENCER_STEP_EN
      stall       <= 1'b0;
`endif
    end else begin
      req_q <= req;
      unique case (state_q)
        StIdle: begin
          if (req_rise) begin
            if (sel_ok) begin
              state_q     <= StLoad;
              start       <= 1'b1;
              busy        <= 1'b1;
              start_addr  <= START_ADDRS[prog_sel*PC_BITS +: PC_BITS];
              done_addr_q <= DONE_ADDRS[prog_sel*PC_BITS +: PC_BITS];
              cycle_count <= '0;
              timeout     <= 1'b0;
              sel_err     <= 1'b0;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          state_q <= StRun;
          start   <= 1'b0;
          first_q <= 1'b1;
`ifdef PROGRAM_SEQUENCER_STEP_EN
          stall   <= ~step;
`endif
        end
        StRun: begin
`ifdef PROGRAM_SEQUENCER_STEP_EN
          stall <= ~step & ~finish;
`endif
          if (advance) begin
            first_q <= 1'b0;
            if (match) begin
              state_q     <= StDone;
              busy        <= 1'b0;
              ack         <= 1'b1;
              cycle_count <= count_inc;
            end else if (budget) begin
              state_q <= StTout;
              busy    <= 1'b0;
              ack     <= 1'b1;
              timeout <= 1'b1;
            end else begin
              cycle_count <= count_inc;
            end
          end
        end
        StDone, StTout: begin
          if (!req) begin
            state_q <= StIdle;
            ack     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed, table-driven bench for program_sequencer with a small budget and custom program map.
module tb_program_sequencer;

  localparam int unsigned PB = 10;
  localparam int unsigned CB = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req;
  logic [1:0]    prog_sel;
  logic [PB-1:0] pc;
  logic          start;
  logic [PB-1:0] start_addr;
  logic          busy;
  logic          ack;
  logic          timeout;
  logic [CB-1:0] cycle_count;
  logic          sel_err;
`ifdef PROGRAM_SEQUENCER_STEP_EN
  logic          step;
  logic          stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  program_sequencer #(
    .PC_BITS    (PB),
    .NUM_PROGS  (3),
    .START_ADDRS({10'd0, 10'd100, 10'd40, 10'd0}),
    .DONE_ADDRS ({10'd0, 10'd7, 10'd40, 10'd23}),
    .CNT_BITS   (CB),
    .MAX_CYCLES (16'd100)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .prog_sel   (prog_sel),
    .pc         (pc),
    .start      (start),
    .start_addr (start_addr),
    .busy       (busy),
    .ack        (ack),
    .timeout    (timeout),
    .cycle_count(cycle_count),
    .sel_err    (sel_err)
`ifdef PROGRAM_SEQUENCER_STEP_EN
    ,
    .step       (step),
    .stall      (stall)
`endif
  );

  typedef struct {
    logic          new_run;
    logic [1:0]    sel;
    logic [PB-1:0] exp_start_addr;
    logic [PB-1:0] pc;
    logic          exp_ack;
    logic [CB-1:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic nr, input logic [1:0] s, input logic [PB-1:0] sa,
                              input logic [PB-1:0] p, input logic a, input logic [CB-1:0] c);
    vec_t v;
    v.new_run = nr; v.sel = s; v.exp_start_addr = sa; v.pc = p; v.exp_ack = a; v.exp_count = c;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Program 0 walks pc 0..23 and finishes on pc 23 with 24 cycles counted.
    for (int k = 0; k < 24; k++)
      vecs.push_back(mk(k == 0, 2'd0, 10'd0, PB'(k), k == 23, CB'(k + 1)));
    // Program 1: start == done, must not finish on the first RUN cycle.
    vecs.push_back(mk(1'b1, 2'd1, 10'd40, 10'd40, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 2'd1, 10'd40, 10'd40, 1'b1, 16'd2));
    // Program 2: done address seen on the first cycle is ignored.
    vecs.push_back(mk(1'b1, 2'd2, 10'd100, 10'd7,   1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 2'd2, 10'd100, 10'd101, 1'b0, 16'd2));
    vecs.push_back(mk(1'b0, 2'd2, 10'd100, 10'd7,   1'b1, 16'd3));

    reset_n = 1'b0; req = 1'b0; prog_sel = 2'd0; pc = '0;
`ifdef PROGRAM_SEQUENCER_STEP_EN
    step = 1'b1;
`endif
    tick(); tick();
    chk("reset_outputs", {start, busy, ack, timeout, sel_err}, 5'b0);
    chk("reset_count", cycle_count, 0);
    reset_n = 1'b1;

    // Out-of-range select is flagged and never launches.
    prog_sel = 2'd3; req = 1'b1;
    tick();
    chk("sel_err_set", sel_err, 1);
    chk("sel_err_no_start", {start, busy}, 2'b00);

    foreach (vecs[i]) begin
      if (vecs[i].new_run) begin
        req = 1'b0;
        tick();
        chk("idle_ack_low", ack, 0);
        prog_sel = vecs[i].sel; req = 1'b1;
        tick();
        chk("load_start", {start, busy, sel_err}, 3'b110);
        chk("load_start_addr", start_addr, vecs[i].exp_start_addr);
        tick();
        chk("run_start_low", {start, busy}, 2'b01);
      end
      pc = vecs[i].pc;
      tick();
      chk("vec_ack", ack, vecs[i].exp_ack);
      chk("vec_busy", busy, !vecs[i].exp_ack);
      chk("vec_count", cycle_count, vecs[i].exp_count);
      chk("vec_timeout", timeout, 0);
    end

    // Held request keeps ack and does not relaunch.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_ack", {ack, start, busy}, 3'b100);
    end
    req = 1'b0;
    tick();
    chk("drop_ack", {ack, busy}, 2'b00);
    chk("drop_count_kept", cycle_count, 3);
    prog_sel = 2'd0; req = 1'b1;
    tick();
    chk("relaunch_start", start, 1);
    chk("relaunch_count_clr", cycle_count, 0);

    // Timeout: pc never reaches 23.
    tick();
    pc = 10'd5;
    for (int i = 0; i < 99; i++) tick();
    chk("tout_pre_ack", ack, 0);
    chk("tout_pre_count", cycle_count, 99);
    tick();
    chk("tout_ack", {ack, timeout, busy}, 3'b110);
    chk("tout_count", cycle_count, 99);
    req = 1'b0;
    tick();
    chk("tout_kept", {ack, timeout}, 2'b01);
    req = 1'b1;
    tick();
    chk("tout_clear_on_accept", {timeout, start}, 2'b01);

    // Match on the budget cycle wins; req drop mid-run is ignored.
    tick();
    for (int i = 0; i < 99; i++) begin
      if (i == 10) req = 1'b0;
      tick();
    end
    chk("simul_pre_ack", ack, 0);
    pc = 10'd23;
    tick();
    chk("simul_ack", {ack, timeout}, 2'b10);
    chk("simul_count", cycle_count, 100);
    tick();
    chk("simul_ack_drop", ack, 0);

    // Reset mid-run.
    pc = 10'd5; req = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_reset_outputs", {busy, start, ack}, 3'b000);
    chk("mid_reset_count", cycle_count, 0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_rise", start, 1);
    reset_n = 1'b0;
    tick();
    chk("reset_in_load", {start, busy}, 2'b00);
    reset_n = 1'b1;
    tick();
    chk("post_reset_rise2", start, 1);

`ifdef PROGRAM_SEQUENCER_STEP_EN
    begin
      int  nadv;
      logic adv;
      logic step_prev;
      nadv = 0; pc = '0;
      for (int i = 0; i < 200; i++) begin
        step = (i % 3 == 0);
        adv = busy & ~start & ~stall;
        step_prev = step;
        tick();
        if (adv) begin
          nadv++;
          pc = pc + 1'b1;
          chk("step_count", cycle_count, nadv);
        end
        if (ack) break;
        if (busy && !start) chk("step_stall", stall, !step_prev);
      end
      chk("step_ack", {ack, stall}, 2'b10);
      chk("step_total", nadv, 24);
      chk("step_final_count", cycle_count, 24);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
